// File: rtl/rob_pkg.sv
// Shared core widths and the reorder-buffer entry layout. The rename table and
// the reservation stations import the same tag and register widths from here.
package rob_pkg;

    localparam int XLEN  = 32;
    localparam int TAG_W = 4;
    localparam int REG_W = 5;
    localparam int DEPTH = 8;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic             valid;
        logic             ready;
        logic [REG_W-1:0] dest;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buf.sv
// In-order retirement buffer: allocates at issue, captures CDB results by tag,
// and retires the oldest completed entry each cycle into the rename table and register file.
module reorder_buf
    import rob_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic [REG_W-1:0] issue_dest,
    input  logic [TAG_W-1:0] issue_tag,
    output logic             issue_ready,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_data,
    input  logic             flush,
    output logic             commit,
    output logic [REG_W-1:0] commit_dest,
    output logic [TAG_W-1:0] commit_tag,
    output logic [XLEN-1:0]  commit_data,
    output logic             rf_we,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    rob_entry_t       entries_q [DEPTH];
    rob_entry_t       entries_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    rob_entry_t       headEntry;
    logic             issueFire;
    logic             cdbFire;

    assign headEntry   = entries_q[head_q];
    assign issue_ready = (count_q < CNT_W'(DEPTH));
    assign issueFire   = issue_valid && issue_ready;
    assign cdbFire     = cdb_valid && (cdb_tag != '0);

    assign commit      = headEntry.valid && headEntry.ready;
    assign commit_dest = commit ? headEntry.dest : '0;
    assign commit_tag  = commit ? headEntry.tag  : '0;
    assign commit_data = commit ? headEntry.data : '0;
    assign rf_we       = commit && (headEntry.dest != '0);
    assign count       = count_q;
    assign empty       = (count_q == '0);

    // Issue is applied after the CDB match so a freshly allocated slot always starts not-ready.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i].valid = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (cdbFire) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (entries_q[i].valid && !entries_q[i].ready && (entries_q[i].tag == cdb_tag)) begin
                        entries_d[i].ready = 1'b1;
                        entries_d[i].data  = cdb_data;
                    end
                end
            end
            if (commit) begin
                entries_d[head_q].valid = 1'b0;
                head_d = head_q + PTR_W'(1);
            end
            if (issueFire) begin
                entries_d[tail_q].valid = 1'b1;
                entries_d[tail_q].ready = 1'b0;
                entries_d[tail_q].dest  = issue_dest;
                entries_d[tail_q].tag   = issue_tag;
                entries_d[tail_q].data  = '0;
                tail_d = tail_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(issueFire) - CNT_W'(commit);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_reorder_buf.sv
// Self-checking bench for reorder_buf: a queue model of in-flight instructions
// is compared against the DUT every cycle, plus directed literal checks.
module tb_reorder_buf;
    import rob_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             issue_valid = 1'b0;
    logic [REG_W-1:0] issue_dest = '0;
    logic [TAG_W-1:0] issue_tag = '0;
    logic             issue_ready;
    logic             cdb_valid = 1'b0;
    logic [TAG_W-1:0] cdb_tag = '0;
    logic [XLEN-1:0]  cdb_data = '0;
    logic             flush = 1'b0;
    logic             commit;
    logic [REG_W-1:0] commit_dest;
    logic [TAG_W-1:0] commit_tag;
    logic [XLEN-1:0]  commit_data;
    logic             rf_we;
    logic [CNT_W-1:0] count;
    logic             empty;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [REG_W-1:0] dest;
        logic [TAG_W-1:0] tag;
        bit               rdy;
        logic [XLEN-1:0]  data;
    } mEntry_t;

    mEntry_t model[$];

    reorder_buf dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_tag(issue_tag),
        .issue_ready(issue_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .flush(flush),
        .commit(commit), .commit_dest(commit_dest), .commit_tag(commit_tag),
        .commit_data(commit_data), .rf_we(rf_we), .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs, lets the rising edge consume them, then returns mid-cycle.
    task automatic applyStimulus(input bit iv, input int dest, input int tag,
                                 input bit cv, input int ctag, input logic [31:0] cdata,
                                 input bit fl);
        issue_valid = iv;
        issue_dest  = REG_W'(dest);
        issue_tag   = TAG_W'(tag);
        cdb_valid   = cv;
        cdb_tag     = TAG_W'(ctag);
        cdb_data    = cdata;
        flush       = fl;
        @(posedge clk);
        #2;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 32'h0, 1'b0);
    endtask

    // Reference behaviour: retire the ready head, wake matching waiters, append the issue if there was room.
    always @(posedge clk) begin
        bit accept;
        accept = (model.size() < DEPTH);
        if (!rst_n || flush) begin
            model.delete();
        end else begin
            if (model.size() > 0 && model[0].rdy) begin
                void'(model.pop_front());
            end
            if (cdb_valid && cdb_tag != '0) begin
                foreach (model[k]) begin
                    if (!model[k].rdy && model[k].tag == cdb_tag) begin
                        model[k].rdy  = 1'b1;
                        model[k].data = cdb_data;
                    end
                end
            end
            if (issue_valid && accept) begin
                model.push_back('{issue_dest, issue_tag, 1'b0, 32'h0});
            end
        end
    end

    always @(negedge clk) begin
        bit               expCommit;
        logic [REG_W-1:0] expDest;
        logic [TAG_W-1:0] expTag;
        logic [XLEN-1:0]  expData;
        if (rst_n) begin
            expCommit = (model.size() > 0) && model[0].rdy;
            expDest   = expCommit ? model[0].dest : '0;
            expTag    = expCommit ? model[0].tag  : '0;
            expData   = expCommit ? model[0].data : '0;
            checkOutput("commit", 32'(commit), 32'(expCommit));
            checkOutput("commit_dest", 32'(commit_dest), 32'(expDest));
            checkOutput("commit_tag", 32'(commit_tag), 32'(expTag));
            checkOutput("commit_data", commit_data, expData);
            checkOutput("rf_we", 32'(rf_we), 32'(expCommit && expDest != 0));
            checkOutput("count", 32'(count), 32'(model.size()));
            checkOutput("empty", 32'(empty), 32'(model.size() == 0));
            checkOutput("issue_ready", 32'(issue_ready), 32'(model.size() < DEPTH));
        end
    end

    initial begin
        int prevTag;
        int ctag;
        bit iv;
        bit cv;

        $display("[TB] reorder_buf bench starting");
        rst_n = 1'b0;
        idleCycle();
        idleCycle();
        rst_n = 1'b1;

        @(negedge clk);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_issue_ready", 32'(issue_ready), 32'd1);
        checkOutput("rst_commit", 32'(commit), 32'd0);
        checkOutput("rst_rf_we", 32'(rf_we), 32'd0);
        checkOutput("rst_commit_data", commit_data, 32'd0);

        // Single issue, CDB next cycle, commit the cycle after.
        applyStimulus(1'b1, 3, 2, 1'b0, 0, 32'h0, 1'b0);
        applyStimulus(1'b0, 0, 0, 1'b1, 2, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        checkOutput("s1_commit", 32'(commit), 32'd1);
        checkOutput("s1_dest", 32'(commit_dest), 32'd3);
        checkOutput("s1_tag", 32'(commit_tag), 32'd2);
        checkOutput("s1_data", commit_data, 32'hDEADBEEF);
        checkOutput("s1_rf_we", 32'(rf_we), 32'd1);
        idleCycle();
        @(negedge clk);
        checkOutput("s1_empty", 32'(empty), 32'd1);

        // Out-of-order completion retires in issue order.
        applyStimulus(1'b1, 4, 1, 1'b0, 0, 32'h0, 1'b0);
        applyStimulus(1'b1, 5, 2, 1'b0, 0, 32'h0, 1'b0);
        applyStimulus(1'b1, 6, 3, 1'b0, 0, 32'h0, 1'b0);
        applyStimulus(1'b0, 0, 0, 1'b1, 3, 32'h33, 1'b0);
        @(negedge clk);
        checkOutput("s2_wait_tag1", 32'(commit), 32'd0);
        applyStimulus(1'b0, 0, 0, 1'b1, 1, 32'h11, 1'b0);
        @(negedge clk);
        checkOutput("s2_commit_dest4", 32'(commit_dest), 32'd4);
        checkOutput("s2_commit_data4", commit_data, 32'h11);
        idleCycle();
        @(negedge clk);
        checkOutput("s2_stall_dest5", 32'(commit), 32'd0);
        checkOutput("s2_count2", 32'(count), 32'd2);
        applyStimulus(1'b0, 0, 0, 1'b1, 2, 32'h22, 1'b0);
        @(negedge clk);
        checkOutput("s2_commit_dest5", 32'(commit_dest), 32'd5);
        idleCycle();
        @(negedge clk);
        checkOutput("s2_commit_dest6", 32'(commit_dest), 32'd6);
        checkOutput("s2_commit_data6", commit_data, 32'h33);
        idleCycle();

        // Fill, reject when full, commit does not free space in the same cycle.
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, i, i, 1'b0, 0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("s3_full_count", 32'(count), 32'd8);
        checkOutput("s3_full_ready", 32'(issue_ready), 32'd0);
        applyStimulus(1'b1, 9, 9, 1'b0, 0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("s3_ninth_ignored", 32'(count), 32'd8);
        applyStimulus(1'b0, 0, 0, 1'b1, 1, 32'hA1, 1'b0);
        @(negedge clk);
        checkOutput("s3_head_commit", 32'(commit), 32'd1);
        applyStimulus(1'b1, 10, 10, 1'b0, 0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("s3_issue_rejected", 32'(count), 32'd7);
        applyStimulus(1'b1, 10, 10, 1'b0, 0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("s3_issue_accepted", 32'(count), 32'd8);
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 32'h0, 1'b1);

        // Back-to-back issue/commit pairs walk the pointers around several times.
        prevTag = 0;
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'b1, i % 32, (i % 15) + 1, (i > 0), prevTag, 32'h1111 * i, 1'b0);
            prevTag = (i % 15) + 1;
        end
        applyStimulus(1'b0, 0, 0, 1'b1, prevTag, 32'hCAFE, 1'b0);
        idleCycle();
        idleCycle();

        // x0 destination retires without a register-file write.
        applyStimulus(1'b1, 0, 5, 1'b0, 0, 32'h0, 1'b0);
        applyStimulus(1'b0, 0, 0, 1'b1, 5, 32'h55, 1'b0);
        @(negedge clk);
        checkOutput("s5_commit", 32'(commit), 32'd1);
        checkOutput("s5_dest", 32'(commit_dest), 32'd0);
        checkOutput("s5_rf_we", 32'(rf_we), 32'd0);
        idleCycle();

        // Flush with a ready head: commit seen that cycle, then everything gone.
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, i + 10, i, 1'b0, 0, 32'h0, 1'b0);
        applyStimulus(1'b0, 0, 0, 1'b1, 1, 32'hF1, 1'b0);
        @(negedge clk);
        checkOutput("s6_head_commit", 32'(commit), 32'd1);
        checkOutput("s6_head_dest", 32'(commit_dest), 32'd11);
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 32'h0, 1'b1);
        @(negedge clk);
        checkOutput("s6_count", 32'(count), 32'd0);
        checkOutput("s6_empty", 32'(empty), 32'd1);
        checkOutput("s6_commit", 32'(commit), 32'd0);
        applyStimulus(1'b0, 0, 0, 1'b1, 2, 32'hF2, 1'b0);
        @(negedge clk);
        checkOutput("s6_stale_cdb", 32'(commit), 32'd0);
        checkOutput("s6_stale_count", 32'(count), 32'd0);

        // Randomized traffic with occasional flush and mid-run reset.
        for (int n = 0; n < 800; n++) begin
            iv = ($urandom % 10) < 7;
            cv = ($urandom % 10) < 6;
            if (model.size() > 0 && ($urandom % 4) != 0)
                ctag = int'(model[$urandom % model.size()].tag);
            else
                ctag = int'($urandom % 16);
            if (($urandom % 250) == 0) rst_n = 1'b0;
            applyStimulus(iv, int'($urandom % 32), int'($urandom_range(1, 15)), cv, ctag,
                          $urandom, ($urandom % 60) == 0);
            rst_n = 1'b1;
        end
        idleCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reorder_buf.md
# reorder_buf

In-order retirement buffer for the Tomasulo core: allocates one entry per issued instruction, captures results from the common data bus (CDB), and retires the oldest completed entry each cycle. On every retirement it drives the commit side of the register rename table (commit, destination register, producing reservation-station tag) and the architectural register-file write port. It is the producer of the commit stream that the rename table consumes.

## Interface
- DEPTH, 8, number of entries (power of two, ≥2)
- XLEN, 32, data width
- TAG_W, 4, reservation-station tag width; tag 0 = "no producer", never allocated
- REG_W, 5, architectural register index width

Ports (reset rst_n, synchronous, active-low; clock clk):
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- issue_valid  in  1  allocate an entry this cycle
- issue_dest  in  REG_W  destination register of issuing instruction
- issue_tag  in  TAG_W  reservation station assigned at issue (1..2^TAG_W-1)
- issue_ready  out  1  buffer can accept an issue (count < DEPTH)
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  producing station of broadcast
- cdb_data  in  XLEN  broadcast result
- flush  in  1  discard all entries (mispredict/exception)
- commit  out  1  head entry retiring this cycle
- commit_dest  out  REG_W  destination of retiring entry (rename table to_zero_index)
- commit_tag  out  TAG_W  producer of retiring entry (rename table original_name)
- commit_data  out  XLEN  value of retiring entry
- rf_we  out  1  commit && commit_dest != 0
- count  out  $clog2(DEPTH)+1  occupied entries
- empty  out  1  count == 0

## Operation
- Per-entry state: valid, ready, dest, tag, data. Circular buffer with head (oldest) and tail (next free) pointers, each $clog2(DEPTH) bits, wrap modulo DEPTH.
- Issue: issue_valid && issue_ready writes entry[tail] = {valid=1, ready=0, dest, tag, data=0}; tail+1. issue_valid while !issue_ready: ignored, no state change.
- issue_ready derives from registered count only; a commit in the same cycle does not free space for an issue when full.
- CDB: cdb_valid && cdb_tag != 0 sets ready=1 and data=cdb_data on every valid, not-ready entry whose tag matches. Entries already ready are untouched. An entry being allocated in the same cycle is not matched (written ready=0). cdb_tag 0 ignored.
- Commit: commit = entry[head].valid && entry[head].ready; commit_* driven combinationally from entry[head] (register outputs only, no input-to-output path). When commit=0, commit_dest/tag/data = 0. On the edge, entry[head].valid cleared, head+1.
- count next = count + (issue accepted) - commit.
- Simultaneous issue+commit with 0 < count < DEPTH: both happen, count unchanged.
- Flush: the commit presented in the flush cycle is taken (head is non-speculative) and must be honoured by consumers; at the edge all valid bits clear, head=tail=0, count=0. Flush overrides issue and CDB in that cycle.
- x0 destination: entry allocated and retires normally; rf_we=0, commit still asserted so the rename table can clear its tag.

## Timing
- Reset: all entries invalid, head=tail=0, count=0, empty=1, issue_ready=1, commit=rf_we=0, commit_dest/tag/data=0.
- Issue to earliest commit: CDB one cycle after issue at the earliest; commit visible the cycle after the CDB edge (CDB edge N -> commit high during cycle N+1).
- Throughput: one issue and one commit per cycle.
- Reset mid-operation discards everything exactly as flush, with no commit honoured.

## Structure
- Shared package rob_pkg: XLEN, TAG_W, REG_W, DEPTH constants and rob_entry_t struct {valid, ready, dest, tag, data}; rename table and reservation stations import the same tag/reg widths.
- Single module; no sub-module needed. Entry array in flops (CDB associative match needs parallel access).

## Test plan
- Reset, then issue {dest=3, tag=2}; CDB {tag=2, data=0xDEADBEEF} next cycle -> following cycle commit=1, commit_dest=3, commit_tag=2, commit_data=0xDEADBEEF, rf_we=1, then empty=1.
- Issue tags 1,2,3 (dests 4,5,6); CDB tag 3 then 1 -> commit of dest 4 only after tag 1 arrives, then 5 stalls until tag 2, then 5 and 6 retire on consecutive cycles.
- Fill 8 entries -> issue_ready=0, count=8; 9th issue ignored; commit one while issuing -> issue still rejected that cycle, accepted next.
- Run >16 issue/commit pairs -> pointer wrap, values retire in issue order, count never exceeds 8.
- Issue dest=0 tag=5, CDB tag 5 -> commit=1, commit_dest=0, rf_we=0.
- 4 entries in flight, head ready, flush -> head commit seen that cycle, next cycle count=0, empty=1, commit=0; subsequent CDB for old tags has no effect.
